// File: rtl/operand_sequencer.sv
// Operand sequencer: runs the load/store/read-modify-write bus cycles for a fetched
// 6502 instruction and hands the operand and N/Z/C flags to the execute stage.
module operand_sequencer #(
   parameter int REG_WIDTH  = 8,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  phi1,
   input  logic                  reset,
   input  logic                  instruction_ready,
   input  logic [REG_WIDTH-1:0]  instruction_in,
   input  logic [ADDR_WIDTH-1:0] addr_in,
   input  logic [REG_WIDTH-1:0]  imm_in,
   input  logic [REG_WIDTH-1:0]  store_data,
   input  logic                  carry_in,
   input  logic [REG_WIDTH-1:0]  data_in,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [REG_WIDTH-1:0]  data_out,
   output logic                  write_en,
   output logic [REG_WIDTH-1:0]  operand_out,
   output logic                  operand_valid,
   output logic                  carry_out,
   output logic                  neg_out,
   output logic                  zero_out,
   output logic                  instruction_done,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_MODIFY, S_WRITE_OLD, S_WRITE_NEW, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      C_LOAD, C_STORE, C_RMW, C_IMM, C_NOBUS
   } class_t;

   state_t                  state_q;
   class_t                  cls_q, cls_d;
   logic                    ready_q;
   logic                    pending_q;
   logic [2:0]              aaa_q;
   logic                    carry_q;
   logic [REG_WIDTH-1:0]    old_q;
   logic [REG_WIDTH-1:0]    result_q;
   logic                    cres_q;
   logic [ADDR_WIDTH-1:0]   bus_addr_q;
   logic [REG_WIDTH-1:0]    data_out_q;
   logic                    write_en_q;
   logic [REG_WIDTH-1:0]    operand_q;
   logic                    valid_q, done_q, carry_out_q, neg_q, zero_q;

   logic [7:0]              op;
   logic                    rise;
   logic [REG_WIDTH-1:0]    rmw_res;
   logic                    rmw_c;
   logic [REG_WIDTH-1:0]    fin_op;
   logic                    fin_c;

   assign op   = instruction_in[7:0];
   assign rise = instruction_ready && !ready_q;

   always_comb begin
      cls_d = C_LOAD;
      if (op inside {8'h81, 8'h84, 8'h85, 8'h86, 8'h8C, 8'h8D, 8'h8E,
                     8'h91, 8'h94, 8'h95, 8'h96, 8'h99, 8'h9D})
         cls_d = C_STORE;
      else if (op[1:0] == 2'b10 && op[7:5] != 3'b100 && op[7:5] != 3'b101 && op[2])
         cls_d = C_RMW;
      else if ((op[1:0] == 2'b01 && op[4:2] == 3'b010) ||
               (op inside {8'hA0, 8'hA2, 8'hC0, 8'hE0}) ||
               (op[1:0] == 2'b00 && op[4:2] == 3'b100))
         cls_d = C_IMM;
      else if (op[3:0] == 4'h8 || op[3:0] == 4'hA ||
               (op inside {8'h00, 8'h20, 8'h40, 8'h4C, 8'h60, 8'h6C}))
         cls_d = C_NOBUS;
   end

   always_comb begin
      rmw_res = old_q;
      rmw_c   = carry_q;
      case (aaa_q)
         3'b000:  {rmw_c, rmw_res} = {old_q, 1'b0};
         3'b001:  {rmw_c, rmw_res} = {old_q, carry_q};
         3'b010:  {rmw_res, rmw_c} = {1'b0, old_q};
         3'b011:  {rmw_res, rmw_c} = {carry_q, old_q};
         3'b110:  rmw_res = old_q - REG_WIDTH'(1);
         3'b111:  rmw_res = old_q + REG_WIDTH'(1);
         default: ;
      endcase
   end

   // Operand/carry latched on whichever transition enters DONE from the current state.
   always_comb begin
      fin_op = '0;
      fin_c  = carry_q;
      case (state_q)
         S_IDLE: begin
            fin_c = carry_in;
            if (cls_d == C_IMM) fin_op = imm_in;
         end
         S_READ: fin_op = data_in;
         S_WRITE_NEW: begin
            if (cls_q == C_RMW) begin
               fin_op = result_q;
               fin_c  = cres_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge phi1) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cls_q       <= C_LOAD;
         ready_q     <= 1'b0;
         pending_q   <= 1'b0;
         aaa_q       <= '0;
         carry_q     <= 1'b0;
         old_q       <= '0;
         result_q    <= '0;
         cres_q      <= 1'b0;
         bus_addr_q  <= '0;
         data_out_q  <= '0;
         write_en_q  <= 1'b0;
         operand_q   <= '0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         carry_out_q <= 1'b0;
         neg_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         ready_q    <= instruction_ready;
         write_en_q <= 1'b0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         if (state_q != S_IDLE && rise) pending_q <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (rise || pending_q) begin
                  pending_q <= 1'b0;
                  cls_q     <= cls_d;
                  aaa_q     <= op[7:5];
                  carry_q   <= carry_in;
                  case (cls_d)
                     C_LOAD, C_RMW: begin
                        bus_addr_q <= addr_in;
                        state_q    <= S_READ;
                     end
                     C_STORE: begin
                        bus_addr_q <= addr_in;
                        data_out_q <= store_data;
                        write_en_q <= 1'b1;
                        state_q    <= S_WRITE_NEW;
                     end
                     default: state_q <= S_DONE;
                  endcase
               end
            end
            S_READ: begin
               old_q   <= data_in;
               state_q <= (cls_q == C_RMW) ? S_MODIFY : S_DONE;
            end
            S_MODIFY: begin
               result_q   <= rmw_res;
               cres_q     <= rmw_c;
               data_out_q <= old_q;
               write_en_q <= 1'b1;
               state_q    <= S_WRITE_OLD;
            end
            S_WRITE_OLD: begin
               data_out_q <= result_q;
               write_en_q <= 1'b1;
               state_q    <= S_WRITE_NEW;
            end
            S_WRITE_NEW: state_q <= S_DONE;
            default:     state_q <= S_IDLE;
         endcase

         if ((state_q == S_IDLE && (rise || pending_q) && (cls_d == C_IMM || cls_d == C_NOBUS)) ||
             (state_q == S_READ && cls_q != C_RMW) || state_q == S_WRITE_NEW) begin
            operand_q   <= fin_op;
            neg_q       <= fin_op[REG_WIDTH-1];
            zero_q      <= (fin_op == '0);
            carry_out_q <= fin_c;
            valid_q     <= 1'b1;
            done_q      <= 1'b1;
         end
      end
   end

   assign bus_addr         = bus_addr_q;
   assign data_out         = data_out_q;
   assign write_en         = write_en_q;
   assign operand_out      = operand_q;
   assign operand_valid    = valid_q;
   assign carry_out        = carry_out_q;
   assign neg_out          = neg_q;
   assign zero_out         = zero_q;
   assign instruction_done = done_q;
   assign busy             = (state_q != S_IDLE);

endmodule
